uart_tx_frame_ctrl: RTL
=======================

# uart_tx_frame_ctrl

Parametrised UART transmit frame controller. Generalises the existing TX control FSM by absorbing the serializer, bit-time counter and parity generator into one block. Supports configurable data width, bit time, parity mode, one/two stop bits and back-to-back frames. Sits between the host-side data handshake and the TX pad; drives `tx_out` directly.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame; legal range 5..9.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 1.
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `p_data` in DATA_WIDTH: parallel payload, sampled on acceptance.
- `data_valid` in 1: host has a frame to send.
- `par_en` in 1: parity bit appended; sampled on acceptance.
- `par_odd` in 1: 0 = even parity, 1 = odd parity; sampled on acceptance.
- `stop2` in 1: 0 = one stop bit, 1 = two stop bits; sampled on acceptance.
- `data_ready` out 1: block can accept a frame this cycle.
- `tx_out` out 1: serial line, idle high; registered.
- `busy` out 1: frame in progress; registered.
- `frame_done` out 1: one-cycle pulse after a frame's final stop bit; registered.

## Operation
- Acceptance: `data_valid & data_ready` at a rising edge. `p_data`, `par_en`, `par_odd` and `stop2` are latched into frame registers. Input changes after acceptance have no effect on the current frame.
- States:
  - IDLE: `tx_out`=1.
  - START: `tx_out`=0.
  - DATA: shift register, LSB first.
  - PARITY: `tx_out`=parity.
  - STOP: `tx_out`=1.
- Every state except IDLE lasts exactly CLKS_PER_BIT cycles per bit. This is enforced by an internal bit timer of width `$clog2(CLKS_PER_BIT+1)`, cleared on every state entry.
- Transitions:
  - IDLE → START on acceptance.
  - START → DATA after 1 bit.
  - DATA → PARITY after DATA_WIDTH bits if latched `par_en`, else DATA → STOP.
  - PARITY → STOP after 1 bit.
  - STOP → after 1 bit, or 2 if latched `stop2`. Goes to START if a new frame is accepted in its final cycle, else to IDLE.
- Parity is the XOR of all latched data bits, inverted when latched `par_odd`=1.
- `data_ready` is high in IDLE and in the final cycle of the final stop bit; low otherwise. It is forced low while `rst` is high.
- Frame length: CLKS_PER_BIT × (1 + DATA_WIDTH + P + S) cycles, where P = parity (0/1) and S = stop bits (1/2).
- Illegal or unreachable state encodings recover to IDLE with `tx_out`=1.

## Timing
- Reset values (cycle after `rst` is sampled high):
  - `tx_out`=1, `busy`=0, `frame_done`=0.
  - `data_ready`=0 while `rst` is high.
  - State IDLE; timer and shift register cleared.
- The first cycle after `rst` deasserts has `data_ready`=1.
- Latency: acceptance at edge k gives `tx_out`=0 and `busy`=1 from edge k onward (visible in cycle k+1).
- `busy` stays high continuously across back-to-back frames. It falls at the edge where the state returns to IDLE.
- `frame_done`: high for exactly one cycle, starting at the edge ending the final stop bit. It still pulses when the next frame starts back-to-back.
- Reset mid-frame: the frame is aborted at that edge and `tx_out` returns to 1 immediately. No partial frame resumes, and `frame_done` does not pulse.
- `data_valid` high while `data_ready` is low is held off. No data is lost as long as the host keeps `data_valid` and `p_data` stable until acceptance.

## Configuration
- Macro: `UART_TX_FRAME_CTRL_PARITY_EN`.
- Defined: full behaviour as above; the PARITY state and parity generator are present.
- Undefined:
  - PARITY state and XOR tree are not built.
  - `par_en` and `par_odd` ports remain but are ignored.
  - DATA always proceeds to STOP.
  - Frame length is CLKS_PER_BIT × (1 + DATA_WIDTH + S).

## Test plan
All scenarios use DATA_WIDTH=8, CLKS_PER_BIT=4, macro defined unless stated.
- Reset: hold `rst`=1 for 3 cycles while `data_valid`=1 → `tx_out`=1, `busy`=0, `data_ready`=0, `frame_done`=0 throughout. `data_ready`=1 in the first cycle after release.
- Basic frame: `p_data`=0xA5, `par_en`=0, `stop2`=0 → `tx_out` bits 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. `busy` high for 40 cycles; one `frame_done` pulse.
- Parity: 0xA5 with `par_en`=1, `par_odd`=0 → parity bit 0. With `par_odd`=1 → 1. 0x07 with even parity → 1. Frame length 44 cycles.
- Two stop bits: 0x3C with `par_en`=1, `stop2`=1 → `tx_out` high for 8 cycles at the end; frame length 48 cycles. `data_ready` high only in the last of those 8 cycles.
- Back-to-back: `data_valid` held high with 0x55, then 0x0F presented immediately after the first acceptance → second start bit begins the cycle after the first frame's last stop cycle. `busy` never drops; `frame_done` pulses twice. Change `p_data` mid-frame → serialized bits unchanged.
- Abort and no-parity build: assert `rst` during DATA bit 3 → `tx_out`=1 and `busy`=0 next cycle, no `frame_done`. With the macro undefined and `par_en`=1 → no parity bit; frame length 40 cycles.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// uart_tx_frame_ctrl
//   UART transmit frame controller: host handshake, bit timer, serializer,
//   optional parity generator and one/two stop bits in a single FSM.
//
//   Build option: define UART_TX_FRAME_CTRL_PARITY_EN to build the PARITY
//   state and parity generator. Without it par_en/par_odd are ignored and
//   every frame goes straight from DATA to STOP.
//
//   Parameters
//     DATA_WIDTH   payload bits per frame (5..9)
//     CLKS_PER_BIT clock cycles per serial bit (>= 1)
//   Ports
//     clk, rst     clock, synchronous active-high reset
//     p_data       payload, latched on acceptance
//     data_valid   host has a frame to send
//     par_en       append parity bit (latched on acceptance)
//     par_odd      0 = even, 1 = odd parity (latched on acceptance)
//     stop2        0 = one stop bit, 1 = two (latched on acceptance)
//     data_ready   frame can be accepted this cycle
//     tx_out       serial line, idle high (registered)
//     busy         frame in progress (registered)
//     frame_done   one-cycle pulse after the final stop bit (registered)
module uart_tx_frame_ctrl #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  stop2,
    output logic                  data_ready,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT + 1);
    localparam int unsigned BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_FRAME_CTRL_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic [TW-1:0]         timer_d;
    logic [BW-1:0]         bit_cnt_q;   // data bit index in DATA, stop bit index in STOP
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  stop2_q;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;
`ifdef UART_TX_FRAME_CTRL_PARITY_EN
    logic                  par_en_q;
    logic                  par_bit_q;
`else
    logic                  unused_par;
    assign unused_par = par_en ^ par_odd;
`endif

    logic bit_last;
    logic stop_last;
    logic ready;
    logic accept;

    assign bit_last  = (timer_q == TIMER_LAST);
    assign stop_last = stop2_q ? (bit_cnt_q == BW'(1)) : 1'b1;
    assign ready     = !rst && ((state_q == S_IDLE) ||
                                ((state_q == S_STOP) && bit_last && stop_last));
    assign accept    = data_valid && ready;

    // Timer restarts on every bit boundary, which covers every state entry.
    always_comb begin
        timer_d = timer_q + TW'(1);
        if (state_q == S_IDLE || bit_last) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            stop2_q   <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef UART_TX_FRAME_CTRL_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            timer_q <= timer_d;
            done_q  <= 1'b0;

            // Acceptance only happens in IDLE or the last STOP cycle, where
            // nothing else touches the frame registers.
            if (accept) begin
                shift_q   <= p_data;
                stop2_q   <= stop2;
`ifdef UART_TX_FRAME_CTRL_PARITY_EN
                par_en_q  <= par_en;
                par_bit_q <= (^p_data) ^ par_odd;
`endif
            end

            case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (accept) begin
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                S_START: begin
                    if (bit_last) begin
                        state_q   <= S_DATA;
                        bit_cnt_q <= '0;
                        tx_q      <= shift_q[0];
                        shift_q   <= shift_q >> 1;
                    end
                end
                S_DATA: begin
                    if (bit_last) begin
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= S_STOP;
                            tx_q      <= 1'b1;
`ifdef UART_TX_FRAME_CTRL_PARITY_EN
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end
`endif
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            tx_q      <= shift_q[0];
                            shift_q   <= shift_q >> 1;
                        end
                    end
                end
`ifdef UART_TX_FRAME_CTRL_PARITY_EN
                S_PARITY: begin
                    if (bit_last) begin
                        state_q   <= S_STOP;
                        bit_cnt_q <= '0;
                        tx_q      <= 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_last) begin
                        if (stop_last) begin
                            done_q    <= 1'b1;
                            bit_cnt_q <= '0;
                            if (accept) begin
                                state_q <= S_START;
                                tx_q    <= 1'b0;
                            end else begin
                                state_q <= S_IDLE;
                                tx_q    <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                        end
                    end
                end
                default: begin
                    state_q   <= S_IDLE;
                    bit_cnt_q <= '0;
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign data_ready = ready;
    assign tx_out     = tx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
